// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with parameterised width, oversample ratio and stop bits.
// It checks parity, framing and break per frame and holds each word in a valid/ready register with overrun tracking.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_tick,
    input  logic                 rx_pin,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 brk,
    output logic                 overrun
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_HALF    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_FULL    = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST    = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        STOP      = 3'd5
    } state_t;

    function automatic logic f_xor(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    logic                 r_sync1, r_sync2, w_rx_s;
    state_t               r_state, w_state;
    logic [SW-1:0]        r_s_count, w_s_count;
    logic [BW-1:0]        r_b_count, w_b_count;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic                 r_par_en, w_par_en, r_par_odd, w_par_odd;
    logic                 r_pbit, w_pbit, r_perr, w_perr, r_ferr, w_ferr;
    logic                 w_commit, w_xfer;
    logic [DATA_BITS-1:0] r_data, w_data;
    logic                 r_valid, w_valid, r_perr_o, w_perr_o, r_ferr_o, w_ferr_o;
    logic                 r_brk, w_brk, r_ovr, w_ovr;

    assign w_rx_s = r_sync2;

    // Two-flop synchroniser; idle-high reset value keeps the line looking quiet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_pin;
            r_sync2 <= r_sync1;
        end
    end

    // Frame FSM next state plus the output holding register update.
    always_comb begin
        w_state   = r_state;
        w_s_count = r_s_count;
        w_b_count = r_b_count;
        w_shift   = r_shift;
        w_par_en  = r_par_en;
        w_par_odd = r_par_odd;
        w_pbit    = r_pbit;
        w_perr    = r_perr;
        w_ferr    = r_ferr;
        w_commit  = 1'b0;
        case (r_state)
            WAIT_IDLE: begin
                if (w_rx_s) w_state = IDLE;
                else        w_state = WAIT_IDLE;
            end
            IDLE: begin
                if (!w_rx_s) begin
                    w_state   = START;
                    w_s_count = '0;
                end else begin
                    w_state = IDLE;
                end
            end
            START: begin
                if (s_tick && r_s_count == S_HALF) begin
                    if (!w_rx_s) begin
                        w_state   = DATA;
                        w_s_count = '0;
                        w_b_count = '0;
                        w_par_en  = parity_en;
                        w_par_odd = parity_odd;
                        w_pbit    = 1'b0;
                        w_perr    = 1'b0;
                        w_ferr    = 1'b0;
                    end else begin
                        w_state = IDLE;
                    end
                end else if (s_tick) begin
                    w_s_count = r_s_count + 1'b1;
                end else begin
                    w_s_count = r_s_count;
                end
            end
            DATA: begin
                if (s_tick && r_s_count == S_FULL) begin
                    w_shift   = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_s_count = '0;
                    if (r_b_count == B_LAST) begin
                        w_b_count = '0;
                        w_state   = r_par_en ? PARITY : STOP;
                    end else begin
                        w_b_count = r_b_count + 1'b1;
                    end
                end else if (s_tick) begin
                    w_s_count = r_s_count + 1'b1;
                end else begin
                    w_s_count = r_s_count;
                end
            end
            PARITY: begin
                if (s_tick && r_s_count == S_FULL) begin
                    w_pbit    = w_rx_s;
                    w_perr    = f_xor(r_shift) ^ w_rx_s ^ r_par_odd;
                    w_s_count = '0;
                    w_state   = STOP;
                end else if (s_tick) begin
                    w_s_count = r_s_count + 1'b1;
                end else begin
                    w_s_count = r_s_count;
                end
            end
            STOP: begin
                if (s_tick && r_s_count == S_FULL) begin
                    w_s_count = '0;
                    w_ferr    = r_ferr | ~w_rx_s;
                    if (r_b_count == STOP_LAST) begin
                        w_b_count = '0;
                        w_commit  = 1'b1;
                        w_state   = w_ferr ? WAIT_IDLE : IDLE;
                    end else begin
                        w_b_count = r_b_count + 1'b1;
                    end
                end else if (s_tick) begin
                    w_s_count = r_s_count + 1'b1;
                end else begin
                    w_s_count = r_s_count;
                end
            end
            default: w_state = WAIT_IDLE;
        endcase

        w_xfer   = r_valid & rx_ready;
        w_data   = r_data;
        w_valid  = r_valid;
        w_perr_o = r_perr_o;
        w_ferr_o = r_ferr_o;
        w_brk    = r_brk;
        w_ovr    = r_ovr;
        if (w_commit) begin
            w_data   = r_shift;
            w_perr_o = r_par_en & r_perr;
            w_ferr_o = w_ferr;
            w_brk    = (r_shift == '0) && !(r_par_en && r_pbit) && w_ferr;
            w_valid  = 1'b1;
            // A commit coinciding with a transfer replaces the word cleanly.
            w_ovr    = r_valid & ~w_xfer;
        end else if (w_xfer) begin
            w_valid = 1'b0;
            w_ovr   = 1'b0;
        end else begin
            w_valid = r_valid;
        end
    end

    // State, counters, frame capture and holding register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= WAIT_IDLE;
            r_s_count <= '0;
            r_b_count <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_pbit    <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr_o  <= 1'b0;
            r_ferr_o  <= 1'b0;
            r_brk     <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_s_count <= w_s_count;
            r_b_count <= w_b_count;
            r_shift   <= w_shift;
            r_par_en  <= w_par_en;
            r_par_odd <= w_par_odd;
            r_pbit    <= w_pbit;
            r_perr    <= w_perr;
            r_ferr    <= w_ferr;
            r_data    <= w_data;
            r_valid   <= w_valid;
            r_perr_o  <= w_perr_o;
            r_ferr_o  <= w_ferr_o;
            r_brk     <= w_brk;
            r_ovr     <= w_ovr;
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign parity_err = r_perr_o;
    assign frame_err  = r_ferr_o;
    assign brk        = r_brk;
    assign overrun    = r_ovr;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: a default instance plus a 7-bit, 2-stop instance with parity.
module tb_uart_rx_cfg;
    localparam int BITC = 160;

    logic clk = 1'b0;
    logic reset_n, s_tick, rx0, rx1, pen0, podd0, pen1, podd1, rdy0, rdy1;
    logic [7:0] d0;
    logic [6:0] d1;
    logic v0, pe0, fe0, bk0, ov0, v1, pe1, fe1, bk1, ov1;

    typedef struct {
        logic [8:0] data;
        logic pe, fe, bk, ov;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int stop_cyc[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg u_dut0 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx_pin(rx0),
        .parity_en(pen0), .parity_odd(podd0), .rx_ready(rdy0),
        .rx_data(d0), .rx_valid(v0), .parity_err(pe0), .frame_err(fe0),
        .brk(bk0), .overrun(ov0)
    );

    uart_rx_cfg #(.DATA_BITS(7), .OVERSAMPLE(16), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx_pin(rx1),
        .parity_en(pen1), .parity_odd(podd1), .rx_ready(rdy1),
        .rx_data(d1), .rx_valid(v1), .parity_err(pe1), .frame_err(fe1),
        .brk(bk1), .overrun(ov1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [8:0] d, input logic pe, input logic fe,
                                input logic bk, input logic ov);
        exp_t e;
        e.data = d; e.pe = pe; e.fe = fe; e.bk = bk; e.ov = ov;
        return e;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int d, input logic b);
        if (d == 0) rx0 = b;
        else        rx1 = b;
        wait_cyc(BITC);
    endtask

    task automatic send(input int d, input logic [8:0] val, input int nd, input logic pen,
                        input logic pbit, input int nstop, input logic stopv);
        drive(d, 1'b0);
        for (int i = 0; i < nd; i++) drive(d, val[i]);
        if (pen) drive(d, pbit);
        for (int i = 0; i < nstop; i++) begin
            if (i == nstop - 1) stop_cyc[d] = cyc;
            drive(d, stopv);
        end
        if (d == 0) rx0 = 1'b1;
        else        rx1 = 1'b1;
    endtask

    // Free-running oversample tick, one pulse every 10 clocks.
    initial begin
        int tc = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            s_tick = (tc == 9);
            tc = (tc == 9) ? 0 : tc + 1;
        end
    end

    // Scoreboard monitor: latency on each rising rx_valid, contents on each transfer.
    always @(negedge clk) begin : mon
        static logic v0_prev = 1'b0;
        static logic v1_prev = 1'b0;
        static logic tick_prev = 1'b0;
        exp_t e;
        if (reset_n === 1'b1) begin
            if (v0 && !v0_prev) begin
                chk("lat0_tick", tick_prev, 1'b1);
                chk("lat0_window", (cyc - stop_cyc[0] >= 60) && (cyc - stop_cyc[0] <= 100), 1'b1);
            end
            if (v1 && !v1_prev) begin
                chk("lat1_tick", tick_prev, 1'b1);
                chk("lat1_window", (cyc - stop_cyc[1] >= 60) && (cyc - stop_cyc[1] <= 100), 1'b1);
            end
            if (v0 && rdy0) begin
                chk("q0_avail", q0.size() != 0, 1'b1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("data0", d0, e.data);
                    chk("flags0", {pe0, fe0, bk0, ov0}, {e.pe, e.fe, e.bk, e.ov});
                end
            end
            if (v1 && rdy1) begin
                chk("q1_avail", q1.size() != 0, 1'b1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("data1", d1, e.data);
                    chk("flags1", {pe1, fe1, bk1, ov1}, {e.pe, e.fe, e.bk, e.ov});
                end
            end
        end
        v0_prev = v0;
        v1_prev = v1;
        tick_prev = s_tick;
    end

    initial begin
        reset_n = 1'b0;
        rx0 = 1'b1; rx1 = 1'b1;
        pen0 = 1'b0; podd0 = 1'b0; pen1 = 1'b1; podd1 = 1'b1;
        rdy0 = 1'b1; rdy1 = 1'b1;
        stop_cyc[0] = 0; stop_cyc[1] = 0;
        wait_cyc(5);
        chk("reset_data", d0, 8'h00);
        chk("reset_flags", {v0, pe0, fe0, bk0, ov0, v1}, 6'b0);
        reset_n = 1'b1;
        wait_cyc(20);

        q0.push_back(mk(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0));
        send(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_cyc(40);
        chk("a5_one_cycle", v0, 1'b0);

        // Odd parity on 0x35 needs a parity bit of 1.
        q1.push_back(mk(9'h035, 1'b0, 1'b0, 1'b0, 1'b0));
        send(1, 9'h035, 7, 1'b1, 1'b1, 2, 1'b1);
        q1.push_back(mk(9'h035, 1'b1, 1'b0, 1'b0, 1'b0));
        send(1, 9'h035, 7, 1'b1, 1'b0, 2, 1'b1);
        wait_cyc(200);

        rx0 = 1'b0;
        wait_cyc(40);
        rx0 = 1'b1;
        wait_cyc(2 * BITC);
        chk("glitch_valid", v0, 1'b0);
        chk("glitch_queue", q0.size(), 0);
        q0.push_back(mk(9'h03C, 1'b0, 1'b0, 1'b0, 1'b0));
        send(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);

        q0.push_back(mk(9'h081, 1'b0, 1'b1, 1'b0, 1'b0));
        send(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b0);
        wait_cyc(2 * BITC);

        // Break: line low for 20 bit times yields exactly one word.
        q0.push_back(mk(9'h000, 1'b0, 1'b1, 1'b1, 1'b0));
        rx0 = 1'b0;
        stop_cyc[0] = cyc + 9 * BITC;
        wait_cyc(20 * BITC);
        chk("break_drained", q0.size(), 0);
        chk("break_valid", v0, 1'b0);
        rx0 = 1'b1;
        wait_cyc(2 * BITC);
        q0.push_back(mk(9'h055, 1'b0, 1'b0, 1'b0, 1'b0));
        send(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1);

        rdy0 = 1'b0;
        send(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
        send(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_cyc(20);
        chk("ovr_set", {v0, ov0}, 2'b11);
        chk("ovr_data", d0, 8'h22);
        q0.push_back(mk(9'h022, 1'b0, 1'b0, 1'b0, 1'b1));
        rdy0 = 1'b1;
        wait_cyc(1);
        rdy0 = 1'b0;
        chk("ovr_clear", {v0, ov0}, 2'b00);

        send(0, 9'h033, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_cyc(20);
        chk("held_33", {v0, d0}, {1'b1, 8'h33});
        drive(0, 1'b0);
        for (int i = 0; i < 3; i++) drive(0, 1'b0);
        wait_cyc(100);
        reset_n = 1'b0;
        #1;
        chk("midreset_data", d0, 8'h00);
        chk("midreset_flags", {v0, pe0, fe0, bk0, ov0}, 5'b0);
        wait_cyc(20);
        reset_n = 1'b1;
        wait_cyc(40);
        rx0 = 1'b1;
        rdy0 = 1'b1;
        wait_cyc(7 * BITC);
        chk("no_partial_valid", v0, 1'b0);
        chk("no_partial_queue", q0.size(), 0);
        q0.push_back(mk(9'h00F, 1'b0, 1'b0, 1'b0, 1'b0));
        send(0, 9'h00F, 8, 1'b0, 1'b0, 1, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            wait_cyc(1);
        end
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
